// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl -- scans an external 8:1 bit mux into an 8-bit word.
//
// The controller steps mux_sel through 0..7, waits SETTLE cycles after each
// select change so the external mux output can settle, samples mux_out into
// bit mux_sel of an internal shift word, and publishes the full word on data
// with a one-cycle data_valid pulse once bit 7 has been captured.
//
// Parameters:
//   SETTLE      wait cycles after each mux_sel change before sampling (0..7)
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       scan request, honoured only while idle
//   continuous  restart a new scan automatically after each completed scan
//   mux_out     bit from the external mux
//   mux_sel     registered select driven to the external mux
//   busy        high while a scan is in progress
//   data        last completed scan word (bit k sampled at mux_sel==k)
//   data_valid  one-cycle pulse when data updates
//   parity      XOR of data bits (only when MUX_SCAN_PARITY_EN is defined)
//
// Optional feature macro: MUX_SCAN_PARITY_EN adds the parity output.

module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic [2:0] mux_sel,
    output logic       busy,
    output logic [7:0] data,
    output logic       data_valid
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Reload value of the settle counter and the state that follows any
    // select change; with no settle time the FSM goes straight to sampling.
    localparam logic [2:0] SETTLE_LD   = 3'(SETTLE);
    localparam state_t     FIRST_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t     state_r;
    logic [2:0] settle_cnt_r;
    logic [7:0] shift_r;

`ifdef MUX_SCAN_PARITY_EN
    function automatic logic parity8(input logic [7:0] word);
        parity8 = ^word;
    endfunction
`endif

    // Scan FSM: owns every piece of state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mux_sel      <= 3'd0;
            settle_cnt_r <= 3'd0;
            shift_r      <= 8'd0;
            data         <= 8'd0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mux_sel      <= 3'd0;
                        settle_cnt_r <= SETTLE_LD;
                        busy         <= 1'b1;
                        state_r      <= FIRST_STATE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_r <= settle_cnt_r - 3'd1;
                    // A count of 0 here can only come from corrupted state;
                    // treat it like the last wait cycle rather than underflow.
                    if (settle_cnt_r <= 3'd1) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_SAMPLE: begin
                    shift_r[mux_sel] <= mux_out;
                    if (mux_sel == 3'd7) begin
                        // Publish the word including the bit captured now;
                        // the shift register is not yet updated this edge.
                        data       <= {mux_out, shift_r[6:0]};
                        data_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        parity     <= parity8({mux_out, shift_r[6:0]});
`endif
                        state_r    <= ST_DONE;
                    end else begin
                        mux_sel      <= mux_sel + 3'd1;
                        settle_cnt_r <= SETTLE_LD;
                        state_r      <= FIRST_STATE;
                    end
                end
                ST_DONE: begin
                    // The only path by which mux_sel returns from 7 to 0.
                    mux_sel <= 3'd0;
                    if (continuous) begin
                        settle_cnt_r <= SETTLE_LD;
                        busy         <= 1'b1;
                        state_r      <= FIRST_STATE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    mux_sel      <= 3'd0;
                    settle_cnt_r <= 3'd0;
                    busy         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the wait cycles after each mux_sel change before sampling (legal range 0..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a scan request, sampled only in IDLE.
REQ-005 The block SHALL have port continuous, input, 1 bit: when 1, a new scan starts automatically after each completed scan.
REQ-006 The block SHALL have port mux_out, input, 1 bit: the output of the external 8:1 bit mux.
REQ-007 The block SHALL have port mux_sel, output, 3 bits: the select driven to the external mux, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any scan is in progress.
REQ-009 The block SHALL have port data, output, 8 bits: the last completed scan word, with bit k sampled at mux_sel==k.
REQ-010 The block SHALL have port data_valid, output, 1 bit: a one-cycle pulse marking an update of data.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-012 In IDLE with start==1, the block SHALL set mux_sel=0 and load settle_cnt=SETTLE, then go to SETTLE, or directly to SAMPLE if SETTLE==0.
REQ-013 In SETTLE, settle_cnt SHALL decrement each cycle, and the FSM SHALL go to SAMPLE on the edge where settle_cnt==1.
REQ-014 In SAMPLE, the block SHALL write mux_out into shift[mux_sel].
  - If mux_sel!=7: increment mux_sel, reload settle_cnt, and return to SETTLE (or SAMPLE if SETTLE==0).
  - If mux_sel==7: go to DONE.
REQ-015 On the SAMPLE edge with mux_sel==7, the block SHALL load data with the full shift word, including the bit just sampled.
REQ-016 data_valid SHALL be 1 exactly during the DONE cycle.
REQ-017 Bit k SHALL be sampled on edge (k+1)*(SETTLE+1) after the start edge, and data_valid SHALL be high in the cycle following edge 8*(SETTLE+1).
REQ-018 In DONE with continuous==1, the block SHALL set mux_sel=0 and start a new scan exactly as in REQ-012; otherwise it SHALL return to IDLE with mux_sel=0.
REQ-019 busy SHALL be 1 in SETTLE, SAMPLE and DONE, and 0 in IDLE.
REQ-020 start SHALL be ignored outside IDLE; no request is queued.
REQ-021 data SHALL hold its value between scans, and a partially scanned word SHALL never appear on data.
REQ-022 mux_sel SHALL wrap 7->0 only via DONE, never by arithmetic overflow.
REQ-023 continuous deasserted mid-scan SHALL let the current scan complete and then return to IDLE.

Reset
REQ-024 rst_n==0 SHALL immediately force state IDLE, mux_sel=0, settle_cnt=0, shift=0, data=0, data_valid=0 and busy=0 (and parity=0 when present), independent of clk.
REQ-025 Reset mid-scan SHALL discard the partial word.
REQ-026 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which it is seen.

Configuration
REQ-027 With macro MUX_SCAN_PARITY_EN defined, the block SHALL have an extra port parity, output, 1 bit, equal to the XOR of the 8 data bits and registered on the same edge as data.
REQ-028 Without MUX_SCAN_PARITY_EN, the parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Basic scan: SETTLE=1, mux model driven by in=8'hA5, one-cycle start -> mux_sel steps 0..7 holding 2 cycles each; data=8'hA5; data_valid is a 1-cycle pulse 16 cycles after the start edge.
REQ-030 Zero settle: SETTLE=0, in=8'h3C -> mux_sel changes every cycle; data=8'h3C with data_valid 8 cycles after start.
REQ-031 Continuous mode: continuous=1, in changes 8'h0F->8'hF0 between scans -> back-to-back data_valid pulses spaced 8*(SETTLE+1)+1 cycles apart carry 8'h0F then 8'hF0; busy stays high throughout.
REQ-032 Ignored start: start pulses at sel 3 of an active scan -> no extra scan; busy falls one cycle after data_valid.
REQ-033 Reset mid-scan: assert rst_n=0 at sel 5 with prior data=8'h5A -> data=0, mux_sel=0 and busy=0 immediately; no data_valid appears.
REQ-034 Parity (MUX_SCAN_PARITY_EN defined): in=8'h07 -> parity=1; in=8'h03 -> parity=0, each updating with data_valid.
